apb_slave_regfile: RTL and testbench



---
 rtl/apb_slave_regfile.sv | 132 +++++++++++++
 tb/tb_apb_slave_regfile.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// APB slave register bank: word 0 is a constant ID, words 1..NUM_REGS-1 are
// byte-strobed read/write registers. Each transfer can be stretched by a fixed
// number of wait states. PSLVERR flags illegal accesses, and a sticky flag
// records an access phase that arrived without a setup phase.
module apb_slave_regfile #(
  parameter int          ADDR_W          = 32,
  parameter int          NUM_REGS        = 8,
  parameter int          WAIT_STATES     = 0,
  parameter logic [31:0] ID_VALUE        = 32'hA9B0_0001,
  parameter bit          PRIV_WRITE_ONLY = 1'b0
) (
  input  logic                   s_axi_clk,
  input  logic                   s_axi_areset,
  input  logic [ADDR_W-1:0]      s_apb_paddr,
  input  logic                   s_apb_psel,
  input  logic                   s_apb_penable,
  input  logic                   s_apb_pwrite,
  input  logic [31:0]            s_apb_pwdata,
  input  logic [3:0]             s_apb_pstrb,
  input  logic [2:0]             s_apb_pprot,
  output logic [31:0]            s_apb_prdata,
  output logic                   s_apb_pready,
  output logic                   s_apb_pslverr,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic                   proto_err
);

  localparam int                IDX_W      = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx;
  logic             complete;
  logic             acc_err;
  logic             wr_en;
  logic [31:0]      rd_word;
  logic             unused_pprot;

  // Only the privileged bit of pprot carries meaning here.
  assign unused_pprot = ^s_apb_pprot[2:1];

  assign idx = s_apb_paddr[IDX_W+1:2];

  // Completion is combinational in the last access cycle; it is held low while
  // reset is asserted, so a transfer caught mid-flight never responds.
  assign complete = !s_axi_areset && (state_q == ACCESS) && s_apb_psel &&
                    s_apb_penable && (cnt_q == 4'd0);

  // Out-of-range includes any nonzero bit above the index field (no aliasing).
  assign acc_err = (s_apb_paddr >= ADDR_LIMIT) ||
                   (s_apb_paddr[1:0] != 2'b00) ||
                   (s_apb_pwrite && (idx == '0)) ||
                   (PRIV_WRITE_ONLY && s_apb_pwrite && !s_apb_pprot[0]);

  assign wr_en = complete && s_apb_pwrite && !acc_err;

  assign s_apb_pready  = complete;
  assign s_apb_pslverr = complete && acc_err;
  assign s_apb_prdata  = (complete && !s_apb_pwrite && !acc_err) ? rd_word : 32'h0;

  // Read mux over the exported words (word 0 is the ID constant).
  always_comb begin
    // NOTE: default assignment first so no path through the loop infers a latch.
    rd_word = 32'h0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == IDX_W'(k)) rd_word = reg_out[32*k +: 32];
    end
  end

  // Transfer sequencing: setup detection, wait-state countdown, abort and
  // detection of an access phase that had no setup phase.
  always_ff @(posedge s_axi_clk) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    if (s_axi_areset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      proto_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_apb_psel && !s_apb_penable) begin
            state_q <= ACCESS;
            cnt_q   <= 4'(WAIT_STATES);
          end else if (s_apb_psel && s_apb_penable) begin
            proto_err <= 1'b1;
          end
        end
        ACCESS: begin
          if (!s_apb_psel) begin
            state_q <= IDLE;
          end else if (!s_apb_penable) begin
            cnt_q <= 4'(WAIT_STATES);
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_word
    if (k == 0) begin : g_id
      assign reg_out[31:0] = ID_VALUE;
    end else begin : g_rw
      logic [31:0] word_q;

      // Byte-strobed update of this word on a legal completing write.
      always_ff @(posedge s_axi_clk) begin
        // NOTE: the register bank is plain flops, so reset clears every word.
        if (s_axi_areset) begin
          word_q <= 32'h0;
        end else if (wr_en && (idx == IDX_W'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (s_apb_pstrb[b]) word_q[8*b +: 8] <= s_apb_pwdata[8*b +: 8];
          end
        end
      end

      assign reg_out[32*k +: 32] = word_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile. Two instances share one APB bus (separate psel):
// dut0 has no wait states and no privilege rule, dut1 has 3 wait states and
// privileged-write-only. A word-level model tracks register contents, error
// rules and per-cycle response expectations; one negedge process compares.
module tb_apb_slave_regfile;

  localparam int          NR = 8;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   paddr, pwdata;
  logic          psel0, psel1, penable, pwrite;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic [31:0]   prdata0, prdata1;
  logic          pready0, pready1, pslverr0, pslverr1, proto0, proto1;
  logic [NR*32-1:0] reg_out0, reg_out1;

  always #5 clk = ~clk;

  apb_slave_regfile #(.ADDR_W(32), .NUM_REGS(NR), .WAIT_STATES(0),
                      .ID_VALUE(ID), .PRIV_WRITE_ONLY(1'b0)) dut0 (
    .s_axi_clk(clk), .s_axi_areset(rst), .s_apb_paddr(paddr),
    .s_apb_psel(psel0), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pprot(pprot),
    .s_apb_prdata(prdata0), .s_apb_pready(pready0), .s_apb_pslverr(pslverr0),
    .reg_out(reg_out0), .proto_err(proto0));

  apb_slave_regfile #(.ADDR_W(32), .NUM_REGS(NR), .WAIT_STATES(3),
                      .ID_VALUE(ID), .PRIV_WRITE_ONLY(1'b1)) dut1 (
    .s_axi_clk(clk), .s_axi_areset(rst), .s_apb_paddr(paddr),
    .s_apb_psel(psel1), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
    .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pprot(pprot),
    .s_apb_prdata(prdata1), .s_apb_pready(pready1), .s_apb_pslverr(pslverr1),
    .reg_out(reg_out1), .proto_err(proto1));

  // ---------------- model ----------------
  logic [31:0] mreg [2][NR];
  logic        mproto [2];
  logic        exp_rdy [2];
  logic        exp_err [2];
  logic [31:0] exp_rd [2];
  logic        chk_on = 1'b0;

  logic        pc_on = 1'b0;
  int          pc_d, pc_idx;
  logic [31:0] pc_data;
  logic [3:0]  pc_strb;
  logic        pp_on [2] = '{1'b0, 1'b0};
  logic        pr_on = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] pack(input int d);
    logic [255:0] v;
    for (int k = 0; k < NR; k++) v[32*k +: 32] = mreg[d][k];
    return v;
  endfunction

  function automatic int wait_states(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < NR; k++) mreg[d][k] = (k == 0) ? ID : 32'h0;
      mproto[d] = 1'b0;
    end
  endtask

  task automatic clear_exp();
    for (int d = 0; d < 2; d++) begin
      exp_rdy[d] = 1'b0;
      exp_err[d] = 1'b0;
      exp_rd[d]  = 32'h0;
    end
  endtask

  // Access rules written straight from the register map.
  task automatic model_eval(input int d, input logic [31:0] a, input logic w,
                            input logic [2:0] pr, output logic e, output logic [31:0] rd);
    logic oor, una;
    int   idx;
    oor = (a >= 32'(NR * 4));
    una = (a[1:0] != 2'b00);
    idx = oor ? 0 : int'(a >> 2);
    e   = oor || una || (w && idx == 0) || (d == 1 && w && !pr[0]);
    rd  = (w || e) ? 32'h0 : mreg[d][idx];
  endtask

  // Advance one clock; apply whatever the last edge committed in the DUTs.
  task automatic step();
    @(posedge clk);
    #1;
    if (pc_on) begin
      for (int b = 0; b < 4; b++)
        if (pc_strb[b]) mreg[pc_d][pc_idx][8*b +: 8] = pc_data[8*b +: 8];
      pc_on = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      if (pp_on[d]) mproto[d] = 1'b1;
      pp_on[d] = 1'b0;
    end
    if (pr_on) begin
      model_reset();
      pr_on = 1'b0;
    end
    clear_exp();
  endtask

  task automatic set_bus(input int d, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
    psel0 = (d == 0);
    psel1 = (d == 1);
    paddr = a; pwrite = w; pwdata = wd; pstrb = st; pprot = pr;
  endtask

  task automatic idle();
    step();
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  // Full transfer; returns during the completing cycle (before its negedge).
  task automatic xfer(input int d, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
    logic        e;
    logic [31:0] rd;
    step();
    set_bus(d, a, w, wd, st, pr);
    penable = 1'b0;
    for (int i = 0; i < wait_states(d); i++) begin
      step();
      penable = 1'b1;
    end
    step();
    penable = 1'b1;
    model_eval(d, a, w, pr, e, rd);
    exp_rdy[d] = 1'b1;
    exp_err[d] = e;
    exp_rd[d]  = rd;
    if (w && !e) begin
      pc_on = 1'b1; pc_d = d; pc_idx = int'(a >> 2); pc_data = wd; pc_strb = st;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      check("pready0",  256'(pready0),  256'(exp_rdy[0]));
      check("pslverr0", 256'(pslverr0), 256'(exp_err[0]));
      check("prdata0",  256'(prdata0),  256'(exp_rd[0]));
      check("reg_out0", reg_out0,       pack(0));
      check("proto0",   256'(proto0),   256'(mproto[0]));
      check("pready1",  256'(pready1),  256'(exp_rdy[1]));
      check("pslverr1", 256'(pslverr1), 256'(exp_err[1]));
      check("prdata1",  256'(prdata1),  256'(exp_rd[1]));
      check("reg_out1", reg_out1,       pack(1));
      check("proto1",   256'(proto1),   256'(mproto[1]));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    paddr = 32'h0; pwrite = 1'b0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b000;
    clear_exp();
    model_reset();
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    step();
    rst = 1'b0;

    // ID read and empty RW read, 2-cycle transfers
    xfer(0, 32'h0, 1'b0, 32'h0, 4'hF, 3'b000);
    @(negedge clk); check("lit_id_read", 256'(prdata0), 256'(32'hA9B0_0001));
    xfer(0, 32'h4, 1'b0, 32'h0, 4'hF, 3'b000);
    @(negedge clk); check("lit_rd4_zero", 256'(prdata0), 256'(32'h0));

    // byte-strobed write, reg_out visible the cycle after commit
    xfer(0, 32'h4, 1'b1, 32'hDEAD_BEEF, 4'b0101, 3'b000);
    idle();
    @(negedge clk); check("lit_regout1", 256'(reg_out0[63:32]), 256'(32'h00AD_00EF));
    xfer(0, 32'h4, 1'b0, 32'h0, 4'h0, 3'b000);
    @(negedge clk); check("lit_rd4", 256'(prdata0), 256'(32'h00AD_00EF));

    // pstrb=0 no-op, legal write at top word, then errors
    xfer(0, 32'h8, 1'b1, 32'hFFFF_FFFF, 4'h0, 3'b000);
    xfer(0, 32'h1C, 1'b1, 32'h0BAD_F00D, 4'hF, 3'b000);
    xfer(0, 32'h0, 1'b1, 32'h1111_1111, 4'hF, 3'b000);
    @(negedge clk); check("lit_err_wr0", 256'(pslverr0), 256'(1'b1));
    xfer(0, 32'h20, 1'b0, 32'h0, 4'hF, 3'b000);
    xfer(0, 32'h6, 1'b1, 32'h2222_2222, 4'hF, 3'b000);
    xfer(0, 32'h1C, 1'b0, 32'h0, 4'hF, 3'b000);
    idle();

    // 3 wait states, privileged write, back-to-back read
    xfer(1, 32'h8, 1'b1, 32'h1234_5678, 4'hF, 3'b001);
    xfer(1, 32'h8, 1'b0, 32'h0, 4'hF, 3'b000);
    @(negedge clk); check("lit_ws3_read", 256'(prdata1), 256'(32'h1234_5678));
    xfer(1, 32'h4, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b000);
    @(negedge clk); check("lit_priv_err", 256'(pslverr1), 256'(1'b1));
    xfer(1, 32'h4, 1'b1, 32'hCAFE_0000, 4'b1100, 3'b001);
    idle();

    // master abort after one access cycle
    step();
    set_bus(1, 32'hC, 1'b1, 32'h5555_5555, 4'hF, 3'b001);
    penable = 1'b0;
    step();
    penable = 1'b1;
    step();
    psel1 = 1'b0; penable = 1'b0;
    idle();
    xfer(1, 32'hC, 1'b0, 32'h0, 4'hF, 3'b000);
    xfer(1, 32'h4, 1'b0, 32'h0, 4'hF, 3'b000);
    idle();

    // access phase without setup -> sticky proto_err
    step();
    set_bus(0, 32'h4, 1'b0, 32'h0, 4'hF, 3'b000);
    penable = 1'b1;
    pp_on[0] = 1'b1;
    idle();
    idle();
    @(negedge clk); check("lit_proto_set", 256'(proto0), 256'(1'b1));
    xfer(0, 32'h4, 1'b0, 32'h0, 4'hF, 3'b000);
    idle();

    // reset in the middle of a wait-stated write
    step();
    set_bus(1, 32'h10, 1'b1, 32'h7777_7777, 4'hF, 3'b001);
    penable = 1'b0;
    step();
    penable = 1'b1;
    step();
    rst = 1'b1;
    pr_on = 1'b1;
    step();
    rst = 1'b0;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(negedge clk); check("lit_proto_clr", 256'(proto0), 256'(1'b0));
    check("lit_regs_clr", reg_out0, 256'(ID));
    for (int k = 0; k < NR; k++) xfer(0, 32'(4 * k), 1'b0, 32'h0, 4'hF, 3'b000);
    xfer(1, 32'h8, 1'b0, 32'h0, 4'hF, 3'b000);
    xfer(1, 32'h10, 1'b0, 32'h0, 4'hF, 3'b000);
    idle();
    idle();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
